// File: rtl/scroll_pkg.sv
// Shared types for the scroll sequencing controller: FSM states and row indexing.
package scroll_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_TICK,
    SHIFT3,
    SHIFT2,
    SHIFT1,
    LOAD,
    W_RESTART,
    W_ROW,
    D_RESTART,
    D_ROW,
    FRAME_DONE
  } state_e;

  localparam int unsigned NUM_ROWS = 4;

  // Row index stored zero-based: 0 selects row 1, 3 selects row 4.
  typedef logic [1:0] row_t;

endpackage

// File: rtl/frame_tick_divider.sv
// Frame tick counter: counts while running, holds at the terminal value while paused.
module frame_tick_divider #(
  parameter int unsigned TICK_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  input  logic pause_i,
  output logic advance_o
);

  localparam int unsigned CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          terminal;

  assign terminal  = (cnt_q == LAST);
  assign advance_o = run_i & terminal & ~pause_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || advance_o) begin
      cnt_d = '0;
    end else if (run_i && !terminal) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scroll_controller.sv
// Per-frame sequencer for the falling-letter datapath: shift/load, then rewrite and redraw four rows.
module scroll_controller
  import scroll_pkg::*;
#(
  parameter int unsigned TICK_CYCLES    = 5_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_048_576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       finish_update,
  output logic       load,
  output logic       shift1,
  output logic       shift2,
  output logic       shift3,
  output logic       restart,
  output logic       update,
  output logic       wren1,
  output logic       wren2,
  output logic       wren3,
  output logic       wren4,
  output logic       draw1,
  output logic       draw2,
  output logic       draw3,
  output logic       draw4,
  output logic       busy,
  output logic       error,
  output logic [7:0] frame_count
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam row_t ROW_LAST = row_t'(NUM_ROWS - 1);

  state_e        state_q, state_d;
  row_t          row_q, row_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [7:0]    frame_q, frame_d;
  logic          tick_adv, tick_clear, tick_run, accept;
  logic [NUM_ROWS-1:0] wr_en, dr_en;

  assign tick_run   = (state_q == WAIT_TICK) && !stop;
  assign tick_clear = (state_q == IDLE) && start && !stop;

  frame_tick_divider #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk      (clk),
    .rst      (reset),
    .clear_i  (tick_clear),
    .run_i    (tick_run),
    .pause_i  (pause),
    .advance_o(tick_adv)
  );

  // tmo_q is zero only in the first cycle of a row visit, which masks a stale flag.
  assign accept = (tmo_q != '0) && finish_update;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    frame_d = frame_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_d = WAIT_TICK;
          err_d   = 1'b0;
        end
        WAIT_TICK: if (tick_adv) state_d = SHIFT3;
        SHIFT3:    state_d = SHIFT2;
        SHIFT2:    state_d = SHIFT1;
        SHIFT1:    state_d = LOAD;
        LOAD: begin
          row_d   = '0;
          state_d = W_RESTART;
        end
        W_RESTART, D_RESTART: begin
          tmo_d   = '0;
          state_d = (state_q == W_RESTART) ? W_ROW : D_ROW;
        end
        W_ROW, D_ROW: begin
          if (accept) begin
            if (row_q != ROW_LAST) begin
              row_d   = row_q + 1'b1;
              state_d = (state_q == W_ROW) ? W_RESTART : D_RESTART;
            end else begin
              row_d   = '0;
              state_d = (state_q == W_ROW) ? D_RESTART : FRAME_DONE;
            end
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        FRAME_DONE: begin
          frame_d = frame_q + 8'd1;
          state_d = WAIT_TICK;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    wr_en = '0;
    dr_en = '0;
    if (state_q == W_ROW) wr_en[row_q] = 1'b1;
    if (state_q == D_ROW) dr_en[row_q] = 1'b1;
  end

  assign shift3      = (state_q == SHIFT3);
  assign shift2      = (state_q == SHIFT2);
  assign shift1      = (state_q == SHIFT1);
  assign load        = (state_q == LOAD);
  assign restart     = (state_q == W_RESTART) || (state_q == D_RESTART);
  assign update      = (state_q == W_ROW) || (state_q == D_ROW);
  assign {wren4, wren3, wren2, wren1} = wr_en;
  assign {draw4, draw3, draw2, draw1} = dr_en;
  assign busy        = (state_q != IDLE) && (state_q != WAIT_TICK);
  assign error       = err_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_scroll_controller.sv
// Directed bench for scroll_controller with short tick and timeout periods.
module tb_scroll_controller;

  logic clk = 1'b0;
  logic reset, start, stop, pause, finish_update;
  logic load, shift1, shift2, shift3, restart, update;
  logic wren1, wren2, wren3, wren4, draw1, draw2, draw3, draw4;
  logic busy, error;
  logic [7:0] frame_count;

  int n_cmp = 0;
  int n_err = 0;
  int fin_mode = 0;   // 0: tied low, 1: tied high, 2: pulse 5 cycles after restart
  int since = 100;
  logic [15:0] hist [0:199];
  logic [7:0]  fhist [0:199];

  // bit 0 shift3,1 shift2,2 shift1,3 load,4 restart,5 update,6-9 wren1-4,10-13 draw1-4,14 busy,15 error
  logic [15:0] obs;
  assign obs = {error, busy, draw4, draw3, draw2, draw1, wren4, wren3, wren2, wren1,
                update, restart, load, shift1, shift2, shift3};

  scroll_controller #(.TICK_CYCLES(8), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .finish_update(finish_update), .load(load), .shift1(shift1), .shift2(shift2),
    .shift3(shift3), .restart(restart), .update(update), .wren1(wren1), .wren2(wren2),
    .wren3(wren3), .wren4(wren4), .draw1(draw1), .draw2(draw2), .draw3(draw3),
    .draw4(draw4), .busy(busy), .error(error), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (restart) since = 0;
    else if (since < 255) since = since + 1;
    case (fin_mode)
      1:       finish_update = 1'b1;
      2:       finish_update = (since == 5);
      default: finish_update = 1'b0;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic record(input int n);
    for (int i = 1; i <= n; i++) begin
      hist[i] = obs; fhist[i] = frame_count; tick();
    end
  endtask

  task automatic wait_bit(input int b, input int bound, input string tag);
    int n = 0;
    while (obs[b] !== 1'b1 && n < bound) begin tick(); n++; end
    check_val(tag, obs[b], 1'b1);
  endtask

  function automatic int first_hi(input int b, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (hist[i][b]) return i;
    return 0;
  endfunction

  function automatic int cnt_hi(input int b, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (hist[i][b]) c++;
    return c;
  endfunction

  initial begin : main
    int exp_first [8] = '{14, 20, 26, 32, 38, 44, 50, 56};
    int viol;
    int n;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; fin_mode = 2;
    repeat (3) tick();
    check_val("reset_outs", obs, 16'h0000);
    check_val("reset_frame", frame_count, 8'd0);
    reset = 1'b0;
    tick();

    // Two frames with the 5-cycle handshake model.
    pulse_start();
    record(125);
    check_val("wait_not_busy", hist[1][14], 1'b0);
    for (int b = 0; b < 4; b++) begin
      check_val($sformatf("strobe%0d_first", b), first_hi(b, 1, 60), 9 + b);
      check_val($sformatf("strobe%0d_once", b), cnt_hi(b, 1, 60), 1);
    end
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("en%0d_first", k), first_hi(6 + k, 1, 61), exp_first[k]);
      check_val($sformatf("en%0d_len", k), cnt_hi(6 + k, 1, 61), 5);
      check_val($sformatf("en%0d_restart_prev", k), hist[exp_first[k] - 1][4], 1'b1);
    end
    viol = 0;
    for (int i = 1; i <= 125; i++)
      if ($countones(hist[i][13:6]) > 1 || (hist[i][4] && (hist[i][13:6] != '0))) viol++;
    check_val("onehot_viol", viol, 0);
    check_val("frame_at61", fhist[61], 8'd0);
    check_val("frame_at62", fhist[62], 8'd1);
    check_val("frame_at122", fhist[122], 8'd1);
    check_val("frame_at123", fhist[123], 8'd2);

    // finish_update tied high: two-cycle rows.
    pulse_stop();
    check_val("stop_idle", obs, 16'h0000);
    fin_mode = 1;
    pulse_start();
    record(45);
    check_val("fast_busy_len", cnt_hi(14, 1, 45), 29);
    for (int k = 0; k < 8; k++)
      check_val($sformatf("fast_en%0d_len", k), cnt_hi(6 + k, 1, 45), 2);
    check_val("fast_frame_37", fhist[37], 8'd2);
    check_val("fast_frame_38", fhist[38], 8'd3);

    // finish_update tied low: timeout in row 1.
    pulse_stop();
    fin_mode = 0;
    pulse_start();
    record(100);
    check_val("tmo_first_row", first_hi(6, 1, 100), 14);
    check_val("tmo_last_wait", hist[77], 16'h4060);
    check_val("tmo_error", hist[78], 16'h8000);
    check_val("tmo_sticky", hist[100], 16'h8000);
    pulse_start();
    check_val("start_clears_err", obs, 16'h0000);

    // Pause held across the tick terminal.
    fin_mode = 2;
    for (int i = 1; i <= 30; i++) begin
      pause = (i <= 20);
      hist[i] = obs; tick();
    end
    pause = 1'b0;
    check_val("pause_no_shift", cnt_hi(0, 1, 21), 0);
    check_val("pause_release", hist[22][0], 1'b1);

    // Asynchronous reset while writing row 3.
    wait_bit(8, 100, "wren3_seen");
    check_val("frame_pre_rst", frame_count, 8'd3);
    #2 reset = 1'b1;
    #1;
    check_val("rst_async_outs", obs, 16'h0000);
    check_val("rst_async_frame", frame_count, 8'd0);
    tick();
    reset = 1'b0;
    tick();

    // Stop in D_ROW keeps frame_count.
    pulse_start();
    n = 0;
    while (frame_count != 8'd1 && n < 200) begin tick(); n++; end
    check_val("frame_one", frame_count, 8'd1);
    wait_bit(11, 100, "draw2_seen");
    stop = 1'b1;
    #1;
    check_val("stop_no_comb", obs[11], 1'b1);
    tick();
    stop = 1'b0;
    check_val("stop_outs", obs, 16'h0000);
    check_val("stop_frame", frame_count, 8'd1);
    repeat (5) tick();
    check_val("stop_stays_idle", obs, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
